// File: rtl/btb_predict_unit.sv
// Direct-mapped branch target buffer with 2-bit direction counters and
// EX-stage misprediction recovery for the next-PC select mux.
module btb_predict_unit #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] FetchPC,
    input  logic        Stall,
    input  logic        ResolveValid,
    input  logic [31:0] ResolvePC,
    input  logic        ResolveTaken,
    input  logic [31:0] ResolveTarget,
    output logic        hit,
    output logic [31:0] PredictorA,
    output logic        r,
    output logic [31:0] Recovery,
    output logic        Flush,
    output logic [15:0] MissCount
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef struct packed {
        logic        v;
        logic        pt;
        logic [31:0] ptgt;
    } rec_t;

    logic                tbl_valid  [ENTRIES];
    logic [TAG_BITS-1:0] tbl_tag    [ENTRIES];
    logic [31:0]         tbl_target [ENTRIES];
    logic [1:0]          tbl_ctr    [ENTRIES];

    rec_t rec_id;
    rec_t rec_ex;

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [INDEX_BITS-1:0] res_idx;
    logic [TAG_BITS-1:0]   res_tag;
    logic                  lookup_taken;
    logic                  res_match;
    logic                  pt_eff;
    logic [1:0]            ctr_next;

    assign fetch_idx = FetchPC[INDEX_BITS+1:2];
    assign fetch_tag = FetchPC[31:INDEX_BITS+2];
    assign res_idx   = ResolvePC[INDEX_BITS+1:2];
    assign res_tag   = ResolvePC[31:INDEX_BITS+2];

    // Lookup reads registered state, so a same-cycle update is not yet visible.
    assign lookup_taken = tbl_valid[fetch_idx] && (tbl_tag[fetch_idx] == fetch_tag)
                          && tbl_ctr[fetch_idx][1];
    assign res_match    = tbl_valid[res_idx] && (tbl_tag[res_idx] == res_tag);

    assign pt_eff = rec_ex.v && rec_ex.pt;
    assign r      = ResolveValid &&
                    ((ResolveTaken != pt_eff) ||
                     (ResolveTaken && pt_eff && (rec_ex.ptgt != ResolveTarget)));

    // The mux favours hit over r, so hit must be masked while recovering.
    assign hit        = lookup_taken && !r;
    assign PredictorA = hit ? tbl_target[fetch_idx] : 32'd0;
    assign Recovery   = r ? (ResolveTaken ? ResolveTarget : ResolvePC + 32'd4) : 32'd0;
    assign Flush      = r;

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        ctr_next = tbl_ctr[res_idx];
        if (ResolveTaken) begin
            if (tbl_ctr[res_idx] != 2'b11) ctr_next = tbl_ctr[res_idx] + 2'b01;
        end else begin
            if (tbl_ctr[res_idx] != 2'b00) ctr_next = tbl_ctr[res_idx] - 2'b01;
        end
    end

    // NOTE: the table is reset entry by entry because the weakly-not-taken counter
    // start value and cleared valid bits are architecturally visible.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= 32'd0;
                tbl_ctr[i]    <= 2'b01;
            end
        end else if (ResolveValid) begin
            if (res_match) begin
                tbl_ctr[res_idx] <= ctr_next;
                if (ResolveTaken) tbl_target[res_idx] <= ResolveTarget;
            end else if (ResolveTaken) begin
                tbl_valid[res_idx]  <= 1'b1;
                tbl_tag[res_idx]    <= res_tag;
                tbl_target[res_idx] <= ResolveTarget;
                tbl_ctr[res_idx]    <= 2'b10;
            end
        end
    end

    // NOTE: non-blocking assignments keep rec_ex sampling the old rec_id on the same edge.
    always_ff @(posedge Clk) begin
        if (Rst || r) begin
            rec_id <= '0;
            rec_ex <= '0;
        end else if (!Stall) begin
            rec_ex <= rec_id;
            rec_id <= '{v: 1'b1, pt: hit, ptgt: PredictorA};
        end else begin
            rec_ex <= '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            MissCount <= 16'd0;
        end else if (r && (MissCount != 16'hFFFF)) begin
            MissCount <= MissCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_btb_predict_unit.sv
// Directed-vector bench for btb_predict_unit: cold/trained branches, wrong
// targets, stall bubbles, PC wrap, mid-run reset and miss-counter saturation.
module tb_btb_predict_unit;

    logic        Clk;
    logic        Rst;
    logic [31:0] FetchPC;
    logic        Stall;
    logic        ResolveValid;
    logic [31:0] ResolvePC;
    logic        ResolveTaken;
    logic [31:0] ResolveTarget;
    logic        hit;
    logic [31:0] PredictorA;
    logic        r;
    logic [31:0] Recovery;
    logic        Flush;
    logic [15:0] MissCount;

    int n_cmp = 0;
    int n_bad = 0;

    btb_predict_unit dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .FetchPC      (FetchPC),
        .Stall        (Stall),
        .ResolveValid (ResolveValid),
        .ResolvePC    (ResolvePC),
        .ResolveTaken (ResolveTaken),
        .ResolveTarget(ResolveTarget),
        .hit          (hit),
        .PredictorA   (PredictorA),
        .r            (r),
        .Recovery     (Recovery),
        .Flush        (Flush),
        .MissCount    (MissCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Fetch pc, fetch pc+4, then resolve pc while refetching pc; stops in the resolve cycle.
    task automatic fetch_and_resolve(input logic [31:0] pc, input logic taken,
                                     input logic [31:0] tgt);
        Stall = 1'b0;
        ResolveValid = 1'b0;
        FetchPC = pc;
        tick();
        FetchPC = pc + 32'd4;
        tick();
        FetchPC = pc;
        ResolveValid = 1'b1;
        ResolvePC = pc;
        ResolveTaken = taken;
        ResolveTarget = tgt;
        #1;
    endtask

    task automatic finish_resolve(input logic [31:0] next_fetch);
        tick();
        ResolveValid = 1'b0;
        ResolveTaken = 1'b0;
        ResolveTarget = 32'd0;
        FetchPC = next_fetch;
        #1;
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        Stall = 1'b0;
        ResolveValid = 1'b0;
        ResolvePC = 32'd0;
        ResolveTaken = 1'b0;
        ResolveTarget = 32'd0;
        FetchPC = 32'h0040_0010;
        tick();
        tick();
        Rst = 1'b0;
        #1;
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit: got %b want 0", hit); end
        n_cmp++; if (PredictorA !== 32'd0) begin n_bad++; $display("FAIL reset_pa: got %h want 0", PredictorA); end
        n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL reset_r: got %b want 0", r); end
        n_cmp++; if (Recovery !== 32'd0) begin n_bad++; $display("FAIL reset_recovery: got %h want 0", Recovery); end
        n_cmp++; if (Flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b want 0", Flush); end
        n_cmp++; if (MissCount !== 16'd0) begin n_bad++; $display("FAIL reset_miss: got %h want 0", MissCount); end
    endtask

    task automatic test_cold_taken;
        fetch_and_resolve(32'h0040_0010, 1'b1, 32'h0040_0100);
        n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL cold_r: got %b want 1", r); end
        n_cmp++; if (Recovery !== 32'h0040_0100) begin n_bad++; $display("FAIL cold_recovery: got %h want 00400100", Recovery); end
        n_cmp++; if (Flush !== 1'b1) begin n_bad++; $display("FAIL cold_flush: got %b want 1", Flush); end
        finish_resolve(32'h0040_0010);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL cold_later_hit: got %b want 1", hit); end
        n_cmp++; if (PredictorA !== 32'h0040_0100) begin n_bad++; $display("FAIL cold_later_pa: got %h want 00400100", PredictorA); end
        n_cmp++; if (MissCount !== 16'd1) begin n_bad++; $display("FAIL cold_miss: got %0d want 1", MissCount); end
    endtask

    task automatic test_train_not_taken;
        // ctr 2 -> 3 with a correct taken prediction.
        fetch_and_resolve(32'h0040_0010, 1'b1, 32'h0040_0100);
        n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL train_correct_r: got %b want 0", r); end
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL train_correct_hit: got %b want 1", hit); end
        finish_resolve(32'h0040_0010);
        fetch_and_resolve(32'h0040_0010, 1'b0, 32'd0);
        n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL nt1_r: got %b want 1", r); end
        n_cmp++; if (Recovery !== 32'h0040_0014) begin n_bad++; $display("FAIL nt1_recovery: got %h want 00400014", Recovery); end
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL nt1_hit_forced: got %b want 0", hit); end
        n_cmp++; if (PredictorA !== 32'd0) begin n_bad++; $display("FAIL nt1_pa_forced: got %h want 0", PredictorA); end
        finish_resolve(32'h0040_0010);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL nt1_ctr2_hit: got %b want 1", hit); end
        n_cmp++; if (MissCount !== 16'd2) begin n_bad++; $display("FAIL nt1_miss: got %0d want 2", MissCount); end
        fetch_and_resolve(32'h0040_0010, 1'b0, 32'd0);
        n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL nt2_r: got %b want 1", r); end
        finish_resolve(32'h0040_0010);
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL nt2_ctr1_hit: got %b want 0", hit); end
        n_cmp++; if (PredictorA !== 32'd0) begin n_bad++; $display("FAIL nt2_ctr1_pa: got %h want 0", PredictorA); end
        n_cmp++; if (MissCount !== 16'd3) begin n_bad++; $display("FAIL nt2_miss: got %0d want 3", MissCount); end
    endtask

    task automatic test_wrong_target;
        // Entry is at ctr=1: a taken outcome mispredicts direction and raises ctr to 2.
        fetch_and_resolve(32'h0040_0010, 1'b1, 32'h0040_0100);
        n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL wt_dir_r: got %b want 1", r); end
        finish_resolve(32'h0040_0010);
        fetch_and_resolve(32'h0040_0010, 1'b1, 32'h0040_0200);
        n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL wt_tgt_r: got %b want 1", r); end
        n_cmp++; if (Recovery !== 32'h0040_0200) begin n_bad++; $display("FAIL wt_tgt_recovery: got %h want 00400200", Recovery); end
        finish_resolve(32'h0040_0010);
        n_cmp++; if (PredictorA !== 32'h0040_0200) begin n_bad++; $display("FAIL wt_rewritten_pa: got %h want 00400200", PredictorA); end
        n_cmp++; if (MissCount !== 16'd5) begin n_bad++; $display("FAIL wt_miss: got %0d want 5", MissCount); end
    endtask

    task automatic test_stall;
        fetch_and_resolve(32'h0040_0040, 1'b1, 32'h0040_0080);
        finish_resolve(32'h0040_0040);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL stall_fetch_hit: got %b want 1", hit); end
        n_cmp++; if (PredictorA !== 32'h0040_0080) begin n_bad++; $display("FAIL stall_fetch_pa: got %h want 00400080", PredictorA); end
        tick();
        Stall = 1'b1;
        FetchPC = 32'h0040_0044;
        tick();
        // Phantom not-taken resolve: only a bubble in rec_ex keeps r low.
        ResolveValid = 1'b1;
        ResolvePC = 32'h0050_0000;
        ResolveTaken = 1'b0;
        ResolveTarget = 32'd0;
        #1;
        n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL stall_bubble_r: got %b want 0", r); end
        tick();
        ResolveValid = 1'b0;
        tick();
        Stall = 1'b0;
        tick();
        ResolveValid = 1'b1;
        ResolvePC = 32'h0040_0040;
        ResolveTaken = 1'b1;
        ResolveTarget = 32'h0040_0080;
        #1;
        n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL stall_release_r: got %b want 0", r); end
        n_cmp++; if (Flush !== 1'b0) begin n_bad++; $display("FAIL stall_release_flush: got %b want 0", Flush); end
        n_cmp++; if (Recovery !== 32'd0) begin n_bad++; $display("FAIL stall_release_recovery: got %h want 0", Recovery); end
        finish_resolve(32'h0040_0040);
        n_cmp++; if (MissCount !== 16'd6) begin n_bad++; $display("FAIL stall_miss: got %0d want 6", MissCount); end
    endtask

    task automatic test_wrap;
        fetch_and_resolve(32'hFFFF_FFFC, 1'b1, 32'h0000_1000);
        finish_resolve(32'hFFFF_FFFC);
        fetch_and_resolve(32'hFFFF_FFFC, 1'b0, 32'd0);
        n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL wrap_r: got %b want 1", r); end
        n_cmp++; if (Recovery !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_recovery: got %h want 00000000", Recovery); end
        finish_resolve(32'h0040_0010);
        n_cmp++; if (MissCount !== 16'd8) begin n_bad++; $display("FAIL wrap_miss: got %0d want 8", MissCount); end
    endtask

    task automatic test_reset_mid;
        Rst = 1'b1;
        Stall = 1'b1;
        ResolveValid = 1'b1;
        ResolvePC = 32'h0040_0010;
        ResolveTaken = 1'b1;
        ResolveTarget = 32'h0040_0300;
        tick();
        Rst = 1'b0;
        Stall = 1'b0;
        ResolveValid = 1'b0;
        ResolveTaken = 1'b0;
        FetchPC = 32'h0040_0010;
        #1;
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL midrst_hit: got %b want 0", hit); end
        n_cmp++; if (MissCount !== 16'd0) begin n_bad++; $display("FAIL midrst_miss: got %0d want 0", MissCount); end
        FetchPC = 32'h0040_0040;
        #1;
        n_cmp++; if (PredictorA !== 32'd0) begin n_bad++; $display("FAIL midrst_pa: got %h want 0", PredictorA); end
    endtask

    task automatic test_saturate;
        // With records cleared every cycle, a held taken resolve mispredicts every cycle.
        Stall = 1'b0;
        ResolveValid = 1'b1;
        ResolvePC = 32'h0060_0000;
        ResolveTaken = 1'b1;
        ResolveTarget = 32'h0060_0100;
        for (int i = 0; i < 65534; i++) tick();
        n_cmp++; if (MissCount !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre: got %h want fffe", MissCount); end
        tick();
        n_cmp++; if (MissCount !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach: got %h want ffff", MissCount); end
        tick();
        tick();
        n_cmp++; if (MissCount !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", MissCount); end
        ResolveValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_taken();
        test_train_not_taken();
        test_wrong_target();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
